// File: rtl/led_uart_tx_pkg.sv
// Shared types and defaults for the LED-to-UART logger: FSM state encoding, byte type, default timing.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package led_uart_tx_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // 25 MHz core clock at 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEF = 217;
    localparam int unsigned FIFO_DEPTH_DEF   = 4;
    // Wide enough for the largest legal CLKS_PER_BIT (65535)
    localparam int unsigned BAUD_W           = 16;

endpackage

// File: rtl/led_uart_tx_if.sv
// LED byte stream in, UART line and status out, bundled for the logger port.
// Latency: n/a (wiring only).
// Backpressure: led_rdy is advisory; the producer never stalls, unaccepted bytes are dropped.
//   led_dat/led_vld : byte and 1-cycle strobe from the ALU LED register
//   led_rdy         : queue not full
//   clr_ovf         : synchronous clear of the sticky overflow flag
//   tx / busy / ovf : UART pin, activity indicator, sticky drop flag
interface led_uart_tx_if;
    import led_uart_tx_pkg::*;

    byte_t led_dat;
    logic  led_vld;
    logic  led_rdy;
    logic  clr_ovf;
    logic  tx;
    logic  busy;
    logic  ovf;

    modport master (
        output led_dat, led_vld, clr_ovf,
        input  led_rdy, tx, busy, ovf
    );

    modport slave (
        input  led_dat, led_vld, clr_ovf,
        output led_rdy, tx, busy, ovf
    );

endinterface

// File: rtl/led_uart_tx_sync_fifo.sv
// Generic synchronous FIFO with registered full/empty flags and wrap-bit pointers.
// Latency: a pushed word is visible at rdata_o and clears empty_o one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; no bypass when full.
//   push_i/wdata_i : write request and data
//   pop_i/rdata_o  : read request and head-of-queue data (combinational from storage)
//   full_o/empty_o : registered status; empty_nxt_o is the value empty_o takes at the next edge
module led_uart_tx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             empty_nxt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        wptr_d  = do_push ? wptr_q + {{AW{1'b0}}, 1'b1} : wptr_q;
        rptr_d  = do_pop  ? rptr_q + {{AW{1'b0}}, 1'b1} : rptr_q;
        // Same slot, different lap -> full; identical pointers -> empty
        full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
        empty_d = (wptr_d == rptr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage carries no reset; the flags guard every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o     = mem_q[rptr_q[AW-1:0]];
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign empty_nxt_o = empty_d;

endmodule

// File: rtl/led_uart_tx.sv
// Queues ALU LED writes and serialises each as one 8N1 UART frame on a registered TX pin.
// Latency: byte pushed into an empty queue at edge N -> start bit on tx at edge N+1; frame = 10*CLKS_PER_BIT.
// Backpressure: never stalls the producer; bytes offered while full are dropped and set sticky ovf.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : slave side of led_uart_tx_if (byte input, tx pin, busy/ready/overflow status)
module led_uart_tx
    import led_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    led_uart_tx_if.slave  bus
);

    tx_state_e   state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]  bit_q;
    byte_t       shift_q;
    logic        tx_q;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;

    byte_t       fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_empty_nxt;
    logic        pop;
    logic        baud_last;
    logic        active_d;
    logic        drop;

    led_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (bus.led_vld),
        .wdata_i     (bus.led_dat),
        .pop_i       (pop),
        .rdata_o     (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .empty_nxt_o (fifo_empty_nxt)
    );

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Head leaves the queue when a frame starts: from idle, or straight out of a finished stop bit
    assign pop = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_head;
                        state_q <= ST_START;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        state_q <= ST_DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q  <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (!fifo_empty) begin
                            // Back-to-back frame: no idle gap after the stop bit
                            shift_q <= fifo_head;
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // busy is built from next-state values and registered, so the pin never glitches
    always_comb begin
        active_d = 1'b1;
        if (state_q == ST_IDLE) begin
            active_d = ~fifo_empty;
        end else if (state_q == ST_STOP) begin
            active_d = ~(baud_last & fifo_empty);
        end
        busy_d = active_d | ~fifo_empty_nxt;
    end

    // A drop wins over a simultaneous clear
    assign drop = bus.led_vld & fifo_full;

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.ovf     = ovf_q;
    assign bus.led_rdy = ~fifo_full;

endmodule

// File: tb/tb_led_uart_tx.sv
// Bench for led_uart_tx: directed table, hand sequences and randomized traffic against a timing model.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_uart_tx;

    localparam int C  = 4;
    localparam int C2 = 2;
    localparam int D  = 4;

    logic clk;
    logic rst_n;

    led_uart_tx_if bus_a ();
    led_uart_tx_if bus_b ();

    led_uart_tx #(.CLKS_PER_BIT(C),  .FIFO_DEPTH(D)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    led_uart_tx #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(D)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of DUT A ----------------
    // Frames are described by their start cycle; the line level is derived arithmetically.
    int          m_t;
    int          m_start;
    int          m_end;
    logic [7:0]  m_cur;
    logic [7:0]  m_q[$];
    logic        m_ovf;

    task automatic model_reset();
        m_t = 0; m_start = 0; m_end = 0; m_cur = '0; m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic c);
        bit full_pre;
        m_t++;
        full_pre = (m_q.size() == D);
        if (m_t >= m_end && m_q.size() > 0) begin
            m_cur   = m_q.pop_front();
            m_start = m_t;
            m_end   = m_t + 10 * C;
        end
        if (v && full_pre)  m_ovf = 1'b1;
        else if (c)         m_ovf = 1'b0;
        if (v && !full_pre) m_q.push_back(d);
    endtask

    function automatic logic model_tx();
        int k;
        if (m_t >= m_end) return 1'b1;
        k = (m_t - m_start) / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    // Drive one cycle on DUT A, advance the model, compare all outputs away from the edge
    task automatic step_a(input logic v, input logic [7:0] d, input logic c, input string tag);
        bus_a.led_vld = v;
        bus_a.led_dat = d;
        bus_a.clr_ovf = c;
        @(posedge clk);
        model_edge(v, d, c);
        @(negedge clk);
        chk({tag, ".tx"},   bus_a.tx,      model_tx());
        chk({tag, ".busy"}, bus_a.busy,    (m_t < m_end) || (m_q.size() > 0));
        chk({tag, ".rdy"},  bus_a.led_rdy, m_q.size() < D);
        chk({tag, ".ovf"},  bus_a.ovf,     m_ovf);
        bus_a.led_vld = 1'b0;
        bus_a.clr_ovf = 1'b0;
    endtask

    task automatic drain_a(input string tag, input int max_cycles);
        int n = 0;
        while (bus_a.busy && n < max_cycles) begin
            step_a(1'b0, 8'h00, 1'b0, tag);
            n++;
        end
        chk({tag, ".drain"}, bus_a.busy, 1'b0);
    endtask

    // Reset asserted between edges; outputs must react without a clock
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus_a.led_vld = 1'b0; bus_a.clr_ovf = 1'b0; bus_a.led_dat = '0;
        bus_b.led_vld = 1'b0; bus_b.clr_ovf = 1'b0; bus_b.led_dat = '0;
        #1;
        chk({tag, ".rst_tx"},   bus_a.tx,      1'b1);
        chk({tag, ".rst_busy"}, bus_a.busy,    1'b0);
        chk({tag, ".rst_rdy"},  bus_a.led_rdy, 1'b1);
        chk({tag, ".rst_ovf"},  bus_a.ovf,     1'b0);
        chk({tag, ".rst_txb"},  bus_b.tx,      1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- line recorder and UART decoder ----------------
    logic       rec_en = 1'b0;
    logic       line_q[$];
    logic [7:0] dec_q[$];
    int         dec_errs, dec_gaps, dec_span;

    always @(negedge clk) begin
        if (rec_en) line_q.push_back(bus_a.tx);
    end

    task automatic decode(input int c);
        int i = 0;
        int first = -1;
        int last_end = 0;
        logic [7:0] b;
        dec_q.delete();
        dec_errs = 0; dec_gaps = 0; dec_span = 0;
        while (i < line_q.size()) begin
            if (line_q[i] == 1'b0) begin
                if (i + 10 * c > line_q.size()) begin
                    dec_errs++;
                    break;
                end
                for (int k = 0; k < c; k++) if (line_q[i+k] != 1'b0) dec_errs++;
                for (int bi = 0; bi < 8; bi++) begin
                    b[bi] = line_q[i + c * (bi + 1)];
                    for (int k = 0; k < c; k++) if (line_q[i + c * (bi + 1) + k] != b[bi]) dec_errs++;
                end
                for (int k = 0; k < c; k++) if (line_q[i + 9 * c + k] != 1'b1) dec_errs++;
                if (first < 0) first = i;
                else           dec_gaps += i - last_end;
                last_end = i + 10 * c;
                dec_q.push_back(b);
                i = last_end;
            end else begin
                i++;
            end
        end
        if (first >= 0) dec_span = last_end - first;
    endtask

    // ---------------- directed table for the first frame ----------------
    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       clr;
        int         hold;
        logic       tx;
        logic       busy;
        logic       rdy;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a5;
        int probs[4];
        int low_run;
        logic sb[24];

        rst_n = 1'b1;
        bus_a.led_vld = 1'b0; bus_a.led_dat = '0; bus_a.clr_ovf = 1'b0;
        bus_b.led_vld = 1'b0; bus_b.led_dat = '0; bus_b.clr_ovf = 1'b0;
        model_reset();

        // ---- 1: single 0xA5 frame, table driven ----
        a5 = 8'hA5;
        tbl.push_back('{1'b1, 8'hA5, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, C, 1'b0, 1'b1, 1'b1, 1'b0});
        for (int bi = 0; bi < 8; bi++)
            tbl.push_back('{1'b0, 8'h00, 1'b0, C, a5[bi], 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, C, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0});

        do_reset("t1");
        for (int r = 0; r < tbl.size(); r++) begin
            for (int h = 0; h < tbl[r].hold; h++) begin
                step_a(tbl[r].vld, tbl[r].dat, tbl[r].clr, "t1m");
                chk($sformatf("t1.r%0d.tx", r),   bus_a.tx,      tbl[r].tx);
                chk($sformatf("t1.r%0d.busy", r), bus_a.busy,    tbl[r].busy);
                chk($sformatf("t1.r%0d.rdy", r),  bus_a.led_rdy, tbl[r].rdy);
                chk($sformatf("t1.r%0d.ovf", r),  bus_a.ovf,     tbl[r].ovf);
            end
        end

        // ---- 2: three back-to-back frames ----
        line_q.delete();
        rec_en = 1'b1;
        step_a(1'b1, 8'h01, 1'b0, "t2");
        chk("t2.rdy0", bus_a.led_rdy, 1'b1);
        step_a(1'b1, 8'h02, 1'b0, "t2");
        chk("t2.rdy1", bus_a.led_rdy, 1'b1);
        step_a(1'b1, 8'h03, 1'b0, "t2");
        chk("t2.rdy2", bus_a.led_rdy, 1'b1);
        drain_a("t2", 200);
        rec_en = 1'b0;
        decode(C);
        chk("t2.nframes", dec_q.size(), 3);
        for (int k = 0; k < 3 && k < dec_q.size(); k++)
            chk($sformatf("t2.byte%0d", k), dec_q[k], k + 1);
        chk("t2.errs", dec_errs, 0);
        chk("t2.gaps", dec_gaps, 0);
        chk("t2.span", dec_span, 30 * C);

        // ---- 3: six-byte burst overflows a four-deep queue ----
        line_q.delete();
        rec_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) chk("t3.rdy_before_drop", bus_a.led_rdy, 1'b0);
            step_a(1'b1, 8'h10 + 8'(k), 1'b0, "t3");
        end
        chk("t3.ovf", bus_a.ovf, 1'b1);
        drain_a("t3", 400);
        rec_en = 1'b0;
        decode(C);
        chk("t3.nframes", dec_q.size(), 5);
        for (int k = 0; k < 5 && k < dec_q.size(); k++)
            chk($sformatf("t3.byte%0d", k), dec_q[k], 8'h10 + k);
        chk("t3.errs", dec_errs, 0);

        // ---- 4: overflow clear, and set winning over clear ----
        step_a(1'b0, 8'h00, 1'b1, "t4");
        chk("t4.clr", bus_a.ovf, 1'b0);
        for (int k = 0; k < 6; k++) step_a(1'b1, 8'h20 + 8'(k), k == 5, "t4");
        chk("t4.set_wins", bus_a.ovf, 1'b1);
        step_a(1'b0, 8'h00, 1'b1, "t4");
        chk("t4.clr2", bus_a.ovf, 1'b0);
        drain_a("t4", 400);

        // ---- 5: reset mid-frame abandons everything ----
        do_reset("t5a");
        step_a(1'b1, 8'hFF, 1'b0, "t5");
        step_a(1'b1, 8'h01, 1'b0, "t5");
        step_a(1'b1, 8'h02, 1'b0, "t5");
        for (int k = 0; k < 7; k++) step_a(1'b0, 8'h00, 1'b0, "t5");
        chk("t5.busy_before", bus_a.busy, 1'b1);
        do_reset("t5b");
        for (int k = 0; k < 30; k++) step_a(1'b0, 8'h00, 1'b0, "t5idle");
        chk("t5.idle_busy", bus_a.busy, 1'b0);
        step_a(1'b1, 8'h00, 1'b0, "t5s");
        step_a(1'b0, 8'h00, 1'b0, "t5s");
        step_a(1'b0, 8'h00, 1'b0, "t5s");
        chk("t5.in_start", bus_a.tx, 1'b0);
        do_reset("t5c");
        for (int k = 0; k < 20; k++) step_a(1'b0, 8'h00, 1'b0, "t5idle2");

        // ---- 6: CLKS_PER_BIT=2, 0x00 frame on DUT B ----
        @(negedge clk);
        bus_b.led_vld = 1'b1;
        bus_b.led_dat = 8'h00;
        @(negedge clk);
        bus_b.led_vld = 1'b0;
        sb[0] = bus_b.tx;
        for (int k = 1; k < 24; k++) begin
            @(negedge clk);
            sb[k] = bus_b.tx;
            if (k == 20) chk("t6.busy_stop", bus_b.busy, 1'b1);
            if (k == 21) chk("t6.busy_after", bus_b.busy, 1'b0);
        end
        chk("t6.latency", sb[0], 1'b1);
        low_run = 0;
        for (int k = 1; k < 24; k++) begin
            if (sb[k] == 1'b0 && low_run == k - 1) low_run++;
        end
        chk("t6.low_run", low_run, 2 * 9 * C2 / 2);
        chk("t6.stop0", sb[19], 1'b1);
        chk("t6.stop1", sb[20], 1'b1);
        chk("t6.idle", sb[23], 1'b1);

        // ---- randomized traffic at several loads ----
        do_reset("rnd");
        probs = '{2, 3, 8, 40};
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 500; i++) begin
                step_a($urandom_range(0, probs[s] - 1) == 0, 8'($urandom),
                       $urandom_range(0, 15) == 0, $sformatf("rnd%0d", s));
            end
        end
        drain_a("rnd", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
